// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared definitions for the memory cycle sequencer: state encodings,
// default phase lengths and the state-flag width.
package mem_seq_pkg;

  localparam int STATE_W = 2;

  localparam int DEF_IDLE_TICKS  = 5;
  localparam int DEF_WRITE_TICKS = 10;
  localparam int DEF_READ_TICKS  = 10;

  // Code 3 is left unnamed on purpose; the FSM treats it as illegal.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_cycle_sequencer_if.sv
// Control/status bundle between the data source, the sequencer and the RAM.
// The master side drives the requests; the slave side is the sequencer.
interface mem_cycle_sequencer_if import mem_seq_pkg::*; #(
  parameter int ADDR_W  = 4,
  parameter int TIMER_W = 8
);

  logic               start;
  logic               loop_mode;
  logic               hold;
  logic               dav;
  logic               mem_en;
  logic               write_en;
  logic [ADDR_W-1:0]  addr;
  logic [STATE_W-1:0] state_flag;
  logic [TIMER_W-1:0] timer_count;
  logic               done;

  modport master (
    output start, loop_mode, hold, dav,
    input  mem_en, write_en, addr, state_flag, timer_count, done
  );

  modport slave (
    input  start, loop_mode, hold, dav,
    output mem_en, write_en, addr, state_flag, timer_count, done
  );

endinterface

// File: rtl/mem_cycle_sequencer_phase_timer.sv
// Phase timer: counts cycles within the current phase, freezes on hold and
// saturates at ref_len-1 so an IDLE phase can wait there for permission.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clock1Hz,
  input  logic               reset,
  input  logic               clear,
  input  logic               hold,
  input  logic [TIMER_W-1:0] ref_len,
  output logic [TIMER_W-1:0] count,
  output logic               expired
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic at_end;

  assign at_end  = (count == (ref_len - ONE));
  assign expired = at_end & ~hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock1Hz or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold && !at_end) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Memory cycle sequencer: steps a RAM through timed Idle -> Write -> Read
// phases, generating enable, write-enable, address and a cycle-done pulse.
module mem_cycle_sequencer import mem_seq_pkg::*; #(
  parameter int ADDR_W      = 4,
  parameter int TIMER_W     = 8,
  parameter int IDLE_TICKS  = DEF_IDLE_TICKS,
  parameter int WRITE_TICKS = DEF_WRITE_TICKS,
  parameter int READ_TICKS  = DEF_READ_TICKS
) (
  input  logic                  clock1Hz,
  input  logic                  reset,
  mem_cycle_sequencer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  addr_q;
  logic               start_pending;
  logic               done_q;
  logic [TIMER_W-1:0] ref_len;
  logic [TIMER_W-1:0] count;
  logic               expired;
  logic               state_change;
  logic               write_en;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    ref_len = TIMER_W'(IDLE_TICKS);
    case (state)
      WRITE:   ref_len = TIMER_W'(WRITE_TICKS);
      READ:    ref_len = TIMER_W'(READ_TICKS);
      default: ref_len = TIMER_W'(IDLE_TICKS);
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (expired && (bus.loop_mode || start_pending)) next_state = WRITE;
      WRITE:   if (expired) next_state = READ;
      READ:    if (expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign state_change = (next_state != state);

  phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock1Hz (clock1Hz),
    .reset    (reset),
    .clear    (state_change),
    .hold     (bus.hold),
    .ref_len  (ref_len),
    .count    (count),
    .expired  (expired)
  );

  assign write_en = (state == WRITE) & bus.dav & ~bus.hold;

  always_ff @(posedge clock1Hz or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= '0;
      start_pending <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (state == READ) && expired;

      // A start seen while the pending one is consumed keeps the latch set.
      if (state == IDLE && next_state == WRITE) begin
        start_pending <= bus.start;
      end else if (bus.start) begin
        start_pending <= 1'b1;
      end

      if (state_change) begin
        addr_q <= '0;
      end else if (write_en || (state == READ && !bus.hold)) begin
        addr_q <= addr_q + ADDR_ONE;
      end
    end
  end

  assign bus.mem_en      = (state == WRITE) || (state == READ);
  assign bus.write_en    = write_en;
  assign bus.addr        = addr_q;
  assign bus.state_flag  = state;
  assign bus.timer_count = count;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Bench for mem_cycle_sequencer: two instances (default and a short-phase,
// 2-bit-address variant) compared every cycle against a phase-level model.
module tb_mem_cycle_sequencer;
  import mem_seq_pkg::*;

  typedef struct {
    int phase;   // 0 idle, 1 write, 2 read
    int cnt;     // cycles spent in the phase (saturating)
    int addr;
    bit pend;
    bit done;
  } model_t;

  typedef struct {
    int depth;
    int t_idle;
    int t_write;
    int t_read;
  } cfg_t;

  logic clock1Hz = 1'b0;
  logic reset    = 1'b1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  bit collect = 1'b0;

  model_t ma, mb;
  cfg_t   ca = '{depth: 16, t_idle: 5, t_write: 10, t_read: 10};
  cfg_t   cb = '{depth: 4,  t_idle: 1, t_write: 6,  t_read: 1};

  int done_at[$];
  int b_waddr[$];

  always #5 clock1Hz = ~clock1Hz;

  mem_cycle_sequencer_if #(.ADDR_W(4), .TIMER_W(8)) bus_a ();
  mem_cycle_sequencer_if #(.ADDR_W(2), .TIMER_W(8)) bus_b ();

  mem_cycle_sequencer #(
    .ADDR_W(4), .TIMER_W(8), .IDLE_TICKS(5), .WRITE_TICKS(10), .READ_TICKS(10)
  ) dut_a (
    .clock1Hz (clock1Hz),
    .reset    (reset),
    .bus      (bus_a)
  );

  mem_cycle_sequencer #(
    .ADDR_W(2), .TIMER_W(8), .IDLE_TICKS(1), .WRITE_TICKS(6), .READ_TICKS(1)
  ) dut_b (
    .clock1Hz (clock1Hz),
    .reset    (reset),
    .bus      (bus_b)
  );

  function automatic model_t zero_model();
    model_t m;
    m.phase = 0; m.cnt = 0; m.addr = 0; m.pend = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  // One clock of the behavioural rules, given the inputs held during the cycle.
  function automatic model_t step(model_t m, cfg_t c, bit start, bit loop, bit hold, bit dav);
    model_t n = m;
    int len;
    bit go, wr;
    len = (m.phase == 0) ? c.t_idle : (m.phase == 1) ? c.t_write : c.t_read;
    wr  = (m.phase == 1) && dav && !hold;
    go  = !hold && (m.cnt == len - 1) && (m.phase != 0 || loop || m.pend);
    n.pend = (m.phase == 0 && go) ? start : (m.pend || start);
    n.done = go && (m.phase == 2);
    if (go) begin
      n.phase = (m.phase + 1) % 3;
      n.cnt   = 0;
      n.addr  = 0;
    end else begin
      if (!hold && m.cnt < len - 1) n.cnt = m.cnt + 1;
      if (wr || (m.phase == 2 && !hold)) n.addr = (m.addr + 1) % c.depth;
    end
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, int exp);
    checks++;
    assert (obs === 32'(exp)) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic compare(string who, model_t m, bit dav, bit hold,
                         logic [31:0] mem_en, logic [31:0] we, logic [31:0] addr,
                         logic [31:0] sf, logic [31:0] tc, logic [31:0] done);
    check({who, ".state_flag"},  sf,     m.phase);
    check({who, ".timer_count"}, tc,     m.cnt);
    check({who, ".addr"},        addr,   m.addr);
    check({who, ".mem_en"},      mem_en, (m.phase != 0) ? 1 : 0);
    check({who, ".write_en"},    we,     (m.phase == 1 && dav && !hold) ? 1 : 0);
    check({who, ".done"},        done,   m.done ? 1 : 0);
  endtask

  task automatic compare_both();
    compare("a", ma, bus_a.dav, bus_a.hold, 32'(bus_a.mem_en), 32'(bus_a.write_en),
            32'(bus_a.addr), 32'(bus_a.state_flag), 32'(bus_a.timer_count), 32'(bus_a.done));
    compare("b", mb, bus_b.dav, bus_b.hold, 32'(bus_b.mem_en), 32'(bus_b.write_en),
            32'(bus_b.addr), 32'(bus_b.state_flag), 32'(bus_b.timer_count), 32'(bus_b.done));
  endtask

  // Check outputs mid-cycle, then advance both models on the rising edge.
  task automatic cycle();
    @(negedge clock1Hz);
    compare_both();
    if (collect && bus_a.done === 1'b1) done_at.push_back(cyc);
    if (collect && bus_b.state_flag === 2'd1) b_waddr.push_back(int'(bus_b.addr));
    @(posedge clock1Hz);
    ma = step(ma, ca, bus_a.start, bus_a.loop_mode, bus_a.hold, bus_a.dav);
    mb = step(mb, cb, bus_b.start, bus_b.loop_mode, bus_b.hold, bus_b.dav);
    cyc++;
    #1;
  endtask

  task automatic drive(bit s, bit l, bit h, bit d);
    bus_a.start = s; bus_a.loop_mode = l; bus_a.hold = h; bus_a.dav = d;
    bus_b.start = s; bus_b.loop_mode = l; bus_b.hold = h; bus_b.dav = d;
  endtask

  // Called just after a rising edge; reset takes effect mid-cycle.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    ma = zero_model();
    mb = zero_model();
    compare_both();
    @(posedge clock1Hz);
    #1 reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_state_a(int sf, int max_cycles, string tag);
    for (int i = 0; i < max_cycles && bus_a.state_flag !== sf[STATE_W-1:0]; i++) cycle();
    check(tag, 32'(bus_a.state_flag), sf);
  endtask

  initial begin
    int b_exp[6] = '{0, 1, 2, 3, 0, 1};
    int dav_pat[4] = '{1, 0, 1, 1};
    int n;
    int prev;

    // Reset state
    drive(0, 0, 0, 0);
    ma = zero_model();
    mb = zero_model();
    #2;
    compare_both();
    @(posedge clock1Hz);
    #1 reset = 1'b0;

    // Loop mode with default phases; B wraps its 2-bit address in WRITE
    drive(0, 1, 0, 1);
    collect = 1'b1;
    repeat (55) cycle();
    collect = 1'b0;
    check("done_count", 32'(done_at.size()), 2);
    check("done_first",  32'((done_at.size() > 0) ? done_at[0] : -1), 25);
    check("done_second", 32'((done_at.size() > 1) ? done_at[1] : -1), 50);
    for (int i = 0; i < 6; i++)
      check("b_wrap_addr", 32'((b_waddr.size() > i) ? b_waddr[i] : -1), b_exp[i]);

    // Reset in the middle of WRITE at addr 3
    for (int i = 0; i < 40 && !(bus_a.state_flag === 2'd1 && bus_a.addr === 4'd3); i++) cycle();
    check("reach_write_addr3", 32'(bus_a.addr), 3);
    apply_reset();
    drive(0, 0, 0, 0);
    repeat (20) cycle();
    check("idle_held_after_reset", 32'(bus_a.state_flag), 0);

    // dav pattern 1,0,1,1 at the start of WRITE
    drive(0, 1, 0, 0);
    wait_state_a(1, 30, "enter_write");
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, dav_pat[i][0]);
      cycle();
    end
    check("addr_after_dav_pattern", 32'(bus_a.addr), 3);

    // Single-shot: start at cycle 7, WRITE from cycle 9
    apply_reset();
    drive(0, 0, 0, 1);
    repeat (7) cycle();
    drive(1, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 1);
    cycle();
    check("single_shot_write", 32'(bus_a.state_flag), 1);
    wait_state_a(2, 20, "single_shot_read");
    drive(1, 0, 0, 1); cycle();
    drive(0, 0, 0, 1); cycle();
    drive(1, 0, 0, 1); cycle();
    drive(0, 0, 0, 1);
    n = 0;
    prev = 2;
    repeat (80) begin
      cycle();
      if (bus_a.state_flag === 2'd1 && prev != 1) n++;
      prev = int'(bus_a.state_flag);
    end
    check("queued_cycles", 32'(n), 1);
    check("idle_after_queue", 32'(bus_a.state_flag), 0);

    // Hold for 3 cycles in READ at timer_count 4
    drive(0, 1, 0, 1);
    wait_state_a(2, 40, "enter_read");
    repeat (4) cycle();
    check("read_tc_before_hold", 32'(bus_a.timer_count), 4);
    drive(0, 1, 1, 1);
    repeat (3) cycle();
    check("hold_tc",    32'(bus_a.timer_count), 4);
    check("hold_addr",  32'(bus_a.addr), 4);
    check("hold_state", 32'(bus_a.state_flag), 2);
    drive(0, 1, 0, 1);
    n = 7;
    for (int i = 0; i < 20 && bus_a.state_flag === 2'd2; i++) begin
      cycle();
      n++;
    end
    check("read_len_with_hold", 32'(n), 13);

    // Hold in WRITE with dav=1 blocks the write
    wait_state_a(1, 30, "enter_write2");
    repeat (2) cycle();
    drive(0, 1, 1, 1);
    #1;
    check("write_en_hold", 32'(bus_a.write_en), 0);
    repeat (2) cycle();
    drive(0, 1, 0, 1);
    #1;
    check("write_en_release", 32'(bus_a.write_en), 1);

    // Randomised traffic on both instances
    for (int i = 0; i < 400; i++) begin
      bus_a.start     = ($urandom_range(0, 9) == 0);
      bus_a.loop_mode = ((i / 60) % 2 == 1) ? 1'b1 : 1'b0;
      bus_a.hold      = ($urandom_range(0, 4) == 0);
      bus_a.dav       = 1'($urandom);
      bus_b.start     = ($urandom_range(0, 6) == 0);
      bus_b.loop_mode = ($urandom_range(0, 3) == 0);
      bus_b.hold      = ($urandom_range(0, 3) == 0);
      bus_b.dav       = 1'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_cycle_sequencer.md
# mem_cycle_sequencer

Parametrised successor to the pratica05 memory control FSM. Sequences a memory through Idle → Write → Read phases on the 1 Hz system clock, using phase durations set by parameters and an internal timer instead of an external trigger. Adds an address generator, single-shot/loop modes, a hold input and a cycle-done pulse. Sits between the data source (dav) and the RAM, driving its enable, write-enable and address lines.

## Interface
- ADDR_W, 4: memory address width; depth = 2**ADDR_W
- TIMER_W, 8: phase timer width
- IDLE_TICKS, 5: Idle phase length in clock cycles (1..2**TIMER_W-1)
- WRITE_TICKS, 10: Write phase length in cycles (same range)
- READ_TICKS, 10: Read phase length in cycles (same range)

- clock1Hz  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request one cycle when loop_mode=0; level-sampled each clock
- loop_mode  in  1  1 = run cycles back-to-back; 0 = run one cycle per start
- hold  in  1  freezes timer and address; blocks writes
- dav  in  1  data available from source
- mem_en  out  1  memory enable
- write_en  out  1  memory write enable
- addr  out  ADDR_W  memory address
- state_flag  out  2  present state encoding
- timer_count  out  TIMER_W  current phase timer value
- done  out  1  one-cycle pulse after each completed Read phase

## Operation
- States: IDLE=0, WRITE=1, READ=2. Code 3 is illegal and goes to IDLE on the next clock.
- Timer: count is cleared to 0 on every state change. It increments each cycle while hold=0. Expiry is count==REF-1 with hold=0, where REF is the current phase's *_TICKS.
- IDLE → WRITE: on expiry when loop_mode=1 or start_pending=1.
  - Otherwise the timer stays at IDLE_TICKS-1 and the block waits.
  - Leaves on the first later cycle where permission holds and hold=0.
- WRITE → READ: on expiry.
- READ → IDLE: on expiry. done is registered high for exactly the first IDLE cycle.
- start_pending:
  - Set by start=1 in any state.
  - Cleared on the IDLE→WRITE transition, unless start=1 in that same cycle.
  - Multiple starts during one cycle queue at most one further cycle.
- Outputs by state:
  - IDLE: mem_en=0, write_en=0, addr=0.
  - WRITE: mem_en=1, write_en = dav & ~hold.
  - READ: mem_en=1, write_en=0.
- Address:
  - Cleared to 0 on entry to WRITE and on entry to READ.
  - WRITE: increments after each cycle with write_en=1.
  - READ: increments after each cycle with hold=0.
  - Wraps from 2**ADDR_W-1 to 0.
- Hold: state, timer and addr frozen. mem_en keeps its state value. write_en=0.
- Reset mid-phase: immediate return to IDLE with all registers cleared. A pending start is discarded.

## Timing
- Reset values: state_flag=0, timer_count=0, addr=0, done=0, mem_en=0, write_en=0, start_pending=0.
- mem_en, write_en and state_flag are combinational from registered state, plus dav/hold for write_en. Same-cycle effect, no added latency.
- addr and timer_count are registered and update on the rising edge.
- Loop mode, hold=0: IDLE lasts IDLE_TICKS cycles, WRITE lasts WRITE_TICKS, READ lasts READ_TICKS. Default period is 25 cycles.
- Single-shot: start sampled at edge N while in IDLE with the timer already expired → WRITE from edge N+1.
- REF=1: the phase lasts exactly one cycle.

## Structure
- Shared package mem_seq_pkg holds:
  - state encodings (IDLE, WRITE, READ)
  - default tick constants (5, 10, 10)
  - the STATE_W=2 constant
- Sub-module phase_timer:
  - inputs: clear, hold, ref[TIMER_W]
  - outputs: count, expired
  - Instantiated once.
- The FSM, start latch, address counter and output decode stay in the top module.

## Test plan
- Reset mid-WRITE: assert reset at addr=3 → all outputs 0 and state_flag=0 immediately. After release, IDLE holds with loop_mode=0 and no start.
- Loop default params, dav=1, hold=0:
  - state_flag sequence 0×5, 1×10, 2×10, repeating.
  - done high in cycles 25 and 50.
  - addr in WRITE runs 0..9; addr in READ runs 0..9.
- dav toggles 1,0,1,1 in WRITE → write_en mirrors dav, and addr ends at 3 after those four cycles.
- Single-shot:
  - loop_mode=0, start pulse at cycle 7 → exactly one WRITE/READ cycle, then IDLE held.
  - A second start during READ → one further cycle, not two.
- Hold 3 cycles in READ at timer_count=4 → timer_count, addr and state frozen, and READ extends to 13 cycles. Hold in WRITE with dav=1 → write_en=0 during the hold.
- ADDR_W=2, WRITE_TICKS=6, dav=1 → addr sequence 0,1,2,3,0,1 (wrap).
